reg_file_2r1w: RTL and testbench
================================

Name: reg_file_2r1w

Overview:
- Register file feeding the ALU's two operand inputs: 2 asynchronous read ports, 1 synchronous write port.
- Located directly upstream of the ALU in the execute datapath.
- Register 0 is hardwired to zero (MIPS convention, matching the ALU control encoding AND/OR/ADD/SUB).
- Write-back data from the ALU result path returns through the write port.

Parameters:
- DATA_W, 32: width of each register and of all data ports.
- ADDR_W, 5: register address width; the file holds 2**ADDR_W registers (32 by default).

Ports:
- clk  input  1  clock; all writes occur on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- read_reg_1  input  ADDR_W  address for read port 1.
- read_reg_2  input  ADDR_W  address for read port 2.
- write_reg  input  ADDR_W  address for the write port.
- write_data  input  DATA_W  data to write.
- reg_write  input  1  write enable; active high.
- read_data_1  output  DATA_W  contents of read_reg_1; drives the ALU operand 1 input.
- read_data_2  output  DATA_W  contents of read_reg_2; drives the ALU operand 2 input.

Behaviour:
- Reset:
  - Clock is clk; reset is rst_n, asynchronous, active-low.
  - rst_n low clears all 2**ADDR_W registers to 0 immediately, independent of clk.
  - While rst_n is low, writes are blocked and read_data_1/read_data_2 read 0 for every address.
  - rst_n low mid-operation discards any pending write: the write whose edge coincides with rst_n low does not occur.
  - The first write after release takes effect on the first rising clk edge at which rst_n is high.
- Write:
  - On rising clk, if rst_n=1, reg_write=1 and write_reg!=0, then regs[write_reg] <= write_data.
  - Write latency is 1 edge: data is readable (base build) right after the edge.
  - reg_write=1 with write_reg=0 is ignored; register 0 stays 0.
  - reg_write=0 means no state change.
- Read:
  - Combinational (0-cycle) from the array: read_data_n = regs[read_reg_n].
  - Address 0 always returns 0.
  - Both ports may address the same register; both return the same value.
- Read during write (same address, same cycle, before the edge):
  - Base build returns the old value until the edge, then the new value.
  - See the Optional Feature for the bypass variant.
- Full address range is valid; there is no out-of-range case.
- No X propagation after reset: every register has a defined value.

Optional Feature:
- Macro: WRITE_BYPASS_EN
- Defined:
  - Read port n returns write_data combinationally when reg_write=1, rst_n=1, write_reg!=0 and write_reg==read_reg_n.
  - This lets a value produced in the same cycle reach the ALU without waiting one edge.
  - Address 0 is never bypassed and still reads 0.
- Undefined: pure array read; the read-during-write rule of the base build applies.

Test Plan:
- Reset clear: write 0xDEADBEEF to r5, pulse rst_n low between clk edges -> read_data_1 (read_reg_1=5) reads 0 immediately, before any clk edge.
- Basic write/read: write 0x00000012 to r3 and 0x00000034 to r7 on two edges; read_reg_1=3, read_reg_2=7 -> 0x12 and 0x34. Check no other register changed by sweeping all 32 addresses.
- Zero register: reg_write=1, write_reg=0, write_data=0xFFFFFFFF at an edge -> read_data_1/read_data_2 with address 0 both read 0.
- Read-during-write: r9=0x1111; set write_reg=9, write_data=0x2222, reg_write=1, read_reg_1=9.
  - Base build: reads 0x1111 before the edge and 0x2222 after it.
  - WRITE_BYPASS_EN: reads 0x2222 before the edge.
- Reset vs write collision: rst_n low across an edge with reg_write=1, write_reg=4, write_data=0xABCD -> r4 reads 0 after rst_n rises. The next edge with the same inputs then yields 0xABCD.
- Write-disable hold: reg_write=0 with write_reg=6, write_data=0x5555 for 3 edges -> r6 keeps its prior value 0x0.

Source files
------------

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: operand register file for the execute stage.
// Two combinational read ports feed the ALU operands; one synchronous write
// port takes the write-back result. Register 0 always reads as zero.
// Optional feature macro: WRITE_BYPASS_EN -- when defined, a read port whose
// address matches an active write returns write_data in the same cycle
// instead of the stored value.
module reg_file_2r1w #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] read_reg_1,
    input  logic [ADDR_W-1:0] read_reg_2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              reg_write,
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2
);

    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];

    // A write is only real when enabled, out of reset and not aimed at r0.
    logic write_en;
    assign write_en = reg_write && rst_n && (write_reg != '0);

    // Storage: reset clears every entry at once; writes land on the rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en) begin
            regs[write_reg] <= write_data;
        end
    end

    // Read ports: r0 forced to zero; the optional bypass forwards the value
    // being written this cycle so a dependent ALU op does not wait an edge.
    always_comb begin
        read_data_1 = '0;
        read_data_2 = '0;
        if (read_reg_1 != '0) begin
`ifdef WRITE_BYPASS_EN
            if (write_en && (write_reg == read_reg_1)) begin
                read_data_1 = write_data;
            end else begin
                read_data_1 = regs[read_reg_1];
            end
`else
            read_data_1 = regs[read_reg_1];
`endif
        end
        if (read_reg_2 != '0) begin
`ifdef WRITE_BYPASS_EN
            if (write_en && (write_reg == read_reg_2)) begin
                read_data_2 = write_data;
            end else begin
                read_data_2 = regs[read_reg_2];
            end
`else
            read_data_2 = regs[read_reg_2];
`endif
        end
    end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: directed checks for reg_file_2r1w (reset clear, basic
// write/read with a full sweep, r0, read-during-write, reset/write collision,
// write-disable hold).
module tb_reg_file_2r1w;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 1 << ADDR_W;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] read_reg_1;
    logic [ADDR_W-1:0] read_reg_2;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic              reg_write;
    logic [DATA_W-1:0] read_data_1;
    logic [DATA_W-1:0] read_data_2;

    int total = 0;
    int bad   = 0;

    // Reference contents, maintained by hand alongside the directed writes.
    logic [DATA_W-1:0] model [NREGS];

    reg_file_2r1w #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .read_reg_1  (read_reg_1),
        .read_reg_2  (read_reg_2),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .reg_write   (reg_write),
        .read_data_1 (read_data_1),
        .read_data_2 (read_data_2)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NREGS; i++) model[i] = '0;
    endtask

    // Read every address on both ports (port 2 walks in reverse order).
    task automatic sweep(input string tag);
        for (int i = 0; i < NREGS; i++) begin
            read_reg_1 = ADDR_W'(i);
            read_reg_2 = ADDR_W'(NREGS - 1 - i);
            #1;
            check($sformatf("%s_p1_r%0d", tag, i), read_data_1, model[i]);
            check($sformatf("%s_p2_r%0d", tag, NREGS - 1 - i), read_data_2,
                  model[NREGS - 1 - i]);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        read_reg_1 = '0;
        read_reg_2 = '0;
        write_reg  = '0;
        write_data = '0;
        reg_write  = 1'b0;
        clear_model();

        // Reset state: everything reads zero.
        read_reg_1 = 5'd5;
        read_reg_2 = 5'd31;
        #2;
        check("reset_p1", read_data_1, 32'h0);
        check("reset_p2", read_data_2, 32'h0);
        edge_step();
        edge_step();
        #3 rst_n = 1'b1;
        edge_step();

        // Reset clear: r5 written, then reset pulsed between edges.
        write_reg  = 5'd5;
        write_data = 32'hDEADBEEF;
        reg_write  = 1'b1;
        edge_step();
        reg_write  = 1'b0;
        read_reg_1 = 5'd5;
        #1;
        check("r5_written", read_data_1, 32'hDEADBEEF);
        #1 rst_n = 1'b0;
        #1;
        check("r5_async_clear", read_data_1, 32'h0);
        #1 rst_n = 1'b1;
        #1;
        check("r5_after_release", read_data_1, 32'h0);
        clear_model();

        // Basic write/read on two edges, then a full sweep.
        edge_step();
        write_reg  = 5'd3;
        write_data = 32'h00000012;
        reg_write  = 1'b1;
        edge_step();
        model[3]   = 32'h00000012;
        write_reg  = 5'd7;
        write_data = 32'h00000034;
        edge_step();
        model[7]   = 32'h00000034;
        reg_write  = 1'b0;
        read_reg_1 = 5'd3;
        read_reg_2 = 5'd7;
        #1;
        check("basic_r3", read_data_1, 32'h00000012);
        check("basic_r7", read_data_2, 32'h00000034);
        read_reg_1 = 5'd7;
        #1;
        check("same_reg_p1", read_data_1, 32'h00000034);
        sweep("sweep1");

        // Zero register: write to r0 is ignored (and never bypassed).
        write_reg  = 5'd0;
        write_data = 32'hFFFFFFFF;
        reg_write  = 1'b1;
        read_reg_1 = 5'd0;
        read_reg_2 = 5'd0;
        #1;
        check("r0_pre_edge_p1", read_data_1, 32'h0);
        check("r0_pre_edge_p2", read_data_2, 32'h0);
        edge_step();
        reg_write = 1'b0;
        #1;
        check("r0_post_edge_p1", read_data_1, 32'h0);
        check("r0_post_edge_p2", read_data_2, 32'h0);

        // Read during write on r9.
        write_reg  = 5'd9;
        write_data = 32'h00001111;
        reg_write  = 1'b1;
        edge_step();
        model[9]   = 32'h00001111;
        reg_write  = 1'b0;
        read_reg_1 = 5'd9;
        #1;
        check("r9_initial", read_data_1, 32'h00001111);
        write_data = 32'h00002222;
        reg_write  = 1'b1;
        #1;
`ifdef WRITE_BYPASS_EN
        check("rdw_before_edge", read_data_1, 32'h00002222);
`else
        check("rdw_before_edge", read_data_1, 32'h00001111);
`endif
        edge_step();
        model[9]  = 32'h00002222;
        reg_write = 1'b0;
        #1;
        check("rdw_after_edge", read_data_1, 32'h00002222);

        // Reset vs write collision on r4.
        write_reg  = 5'd4;
        write_data = 32'h0000ABCD;
        reg_write  = 1'b1;
        read_reg_1 = 5'd4;
        read_reg_2 = 5'd9;
        #1 rst_n = 1'b0;
        #1;
        check("coll_in_reset_p1", read_data_1, 32'h0);
        check("coll_in_reset_p2", read_data_2, 32'h0);
        edge_step();
        check("coll_after_edge_r4", read_data_1, 32'h0);
        clear_model();
        #1 rst_n = 1'b1;
        reg_write = 1'b0;
        #1;
        check("coll_released_r4", read_data_1, 32'h0);
        check("coll_released_r9", read_data_2, 32'h0);
        reg_write = 1'b1;
        edge_step();
        model[4]  = 32'h0000ABCD;
        reg_write = 1'b0;
        #1;
        check("coll_next_edge_r4", read_data_1, 32'h0000ABCD);

        // Write-disable hold on r6 for three edges.
        write_reg  = 5'd6;
        write_data = 32'h00005555;
        reg_write  = 1'b0;
        read_reg_1 = 5'd6;
        for (int k = 0; k < 3; k++) begin
            edge_step();
            check($sformatf("hold_r6_edge%0d", k), read_data_1, 32'h0);
        end

        // Final sweep: collision reset cleared r3/r7/r9, only r4 remains.
        sweep("sweep2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
